// File: rtl/bus_xfer_sched_pkg.sv
// ----------------------------------------------------------------------------
// bus_xfer_sched_pkg
// Shared definitions for the bus transfer scheduler: FSM state encodings,
// the idle bus-mux select code, the highest valid source code and the
// source codes understood by the CPU bus mux.
// No ports (package).
// ----------------------------------------------------------------------------
package bus_xfer_sched_pkg;

  // Scheduler states; IDLE arbitrates, DRIVE lets the bus settle,
  // LOAD pulses the destination enables and the grant.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_LOAD  = 2'd2
  } state_t;

  // Mux select that makes the bus read as zero.
  localparam logic [4:0] SEL_IDLE = 5'd31;

  // Any source code above this one has no mux input behind it.
  localparam logic [4:0] SRC_MAX_VALID = 5'd23;

  // Source codes as wired on the bus mux.
  typedef enum logic [4:0] {
    SRC_R0     = 5'd0,
    SRC_R1     = 5'd1,
    SRC_R2     = 5'd2,
    SRC_R3     = 5'd3,
    SRC_R4     = 5'd4,
    SRC_R5     = 5'd5,
    SRC_R6     = 5'd6,
    SRC_R7     = 5'd7,
    SRC_R8     = 5'd8,
    SRC_R9     = 5'd9,
    SRC_R10    = 5'd10,
    SRC_R11    = 5'd11,
    SRC_R12    = 5'd12,
    SRC_R13    = 5'd13,
    SRC_R14    = 5'd14,
    SRC_R15    = 5'd15,
    SRC_HI     = 5'd16,
    SRC_LO     = 5'd17,
    SRC_ZHI    = 5'd18,
    SRC_ZLO    = 5'd19,
    SRC_PC     = 5'd20,
    SRC_MDR    = 5'd21,
    SRC_INPORT = 5'd22,
    SRC_CSIGN  = 5'd23
  } src_code_t;

endpackage

// File: rtl/bus_xfer_sched_if.sv
// ----------------------------------------------------------------------------
// bus_xfer_sched_if
// Groups the requester handshake and the bus-side outputs of the transfer
// scheduler.
//   req      requester -> scheduler  per-requester level request
//   req_src  requester -> scheduler  packed source codes, SEL_W per requester
//   req_dst  requester -> scheduler  packed destination vectors, DST_W each
//   select   scheduler -> bus        registered bus-mux select
//   dst_en   scheduler -> regfile    registered destination load enables
//   grant    scheduler -> requester  one-hot completion pulse
//   src_err  scheduler -> requester  pulse, granted source code was invalid
//   busy     scheduler -> requester  high while a transfer is in flight
// Modports: master (requester side), slave (scheduler side).
// ----------------------------------------------------------------------------
interface bus_xfer_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int SEL_W   = 5,
  parameter int DST_W   = 24
);

  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*SEL_W-1:0] req_src;
  logic [NUM_REQ*DST_W-1:0] req_dst;
  logic [SEL_W-1:0]         select;
  logic [DST_W-1:0]         dst_en;
  logic [NUM_REQ-1:0]       grant;
  logic                     src_err;
  logic                     busy;

  modport master (
    output req, req_src, req_dst,
    input  select, dst_en, grant, src_err, busy
  );

  modport slave (
    input  req, req_src, req_dst,
    output select, dst_en, grant, src_err, busy
  );

endinterface

// File: rtl/bus_xfer_sched_rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Combinational pick of one requester out of req & ~mask.
//   i_ptr     round-robin start index (absent in fixed-priority builds)
//   i_req     request vector
//   i_mask    requesters excluded from this pick
//   o_winner  one-hot winner
//   o_idx     binary index of the winner
//   o_valid   at least one requester was eligible
// Build option: BUS_XFER_SCHED_FIXED_PRIO_EN selects fixed priority (lowest
// index wins); otherwise the search starts at i_ptr and wraps.
// ----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
`ifndef BUS_XFER_SCHED_FIXED_PRIO_EN
  input  logic [IDX_W-1:0]   i_ptr,
`endif
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [NUM_REQ-1:0] i_mask,
  output logic [NUM_REQ-1:0] o_winner,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_valid
);

  logic [NUM_REQ-1:0] w_elig;

  assign w_elig = i_req & ~i_mask;

  // The round-robin search runs in two passes: first the indices at or
  // above the pointer, then a full pass from zero that only takes effect
  // if the first pass found nothing, which is the wrap-around. The fixed
  // priority build keeps only the second pass.
  always_comb begin
    o_winner = '0;
    o_idx    = '0;
    o_valid  = 1'b0;
`ifndef BUS_XFER_SCHED_FIXED_PRIO_EN
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!o_valid && w_elig[i] && (i >= int'(i_ptr))) begin
        o_valid     = 1'b1;
        o_winner[i] = 1'b1;
        o_idx       = IDX_W'(i);
      end
    end
`endif
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!o_valid && w_elig[i]) begin
        o_valid     = 1'b1;
        o_winner[i] = 1'b1;
        o_idx       = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/bus_xfer_sched.sv
// ----------------------------------------------------------------------------
// bus_xfer_sched
// Arbitrates register-to-register transfers over the shared CPU bus. One
// requester is granted at a time: its source code drives the bus-mux select
// for a settle cycle, then its destination load enables pulse for one cycle
// together with the grant.
//   clock  rising-edge clock
//   clear  synchronous active-high reset
//   bus    bus_xfer_sched_if.slave: req/req_src/req_dst in,
//          select/dst_en/grant/src_err/busy out (all registered)
// Build option: BUS_XFER_SCHED_FIXED_PRIO_EN gives fixed lowest-index
// priority and drops the round-robin pointer.
// ----------------------------------------------------------------------------
module bus_xfer_sched
  import bus_xfer_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int SEL_W   = 5,
  parameter int DST_W   = 24
) (
  input logic              clock,
  input logic              clear,
  bus_xfer_sched_if.slave  bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [SEL_W-1:0] SEL_IDLE_W = SEL_W'(SEL_IDLE);
  localparam logic [SEL_W-1:0] SRC_MAX_W  = SEL_W'(SRC_MAX_VALID);

  state_t             r_state;
  logic [SEL_W-1:0]   r_select;
  logic [DST_W-1:0]   r_dstEn;
  logic [DST_W-1:0]   r_holdDst;
  logic [NUM_REQ-1:0] r_grant;
  logic [NUM_REQ-1:0] r_winOh;
  logic [NUM_REQ-1:0] r_mask;
  logic               r_srcErr;
  logic               r_busy;
`ifndef BUS_XFER_SCHED_FIXED_PRIO_EN
  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   r_winIdx;
`endif

  logic [NUM_REQ-1:0] w_winner;
  logic [IDX_W-1:0]   w_winIdx;
  logic               w_anyElig;
  logic [SEL_W-1:0]   w_src;
  logic [DST_W-1:0]   w_dst;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
`ifndef BUS_XFER_SCHED_FIXED_PRIO_EN
    .i_ptr    (r_ptr),
`endif
    .i_req    (bus.req),
    .i_mask   (r_mask),
    .o_winner (w_winner),
    .o_idx    (w_winIdx),
    .o_valid  (w_anyElig)
  );

  assign w_src = bus.req_src[int'(w_winIdx)*SEL_W +: SEL_W];
  assign w_dst = bus.req_dst[int'(w_winIdx)*DST_W +: DST_W];

  assign bus.select  = r_select;
  assign bus.dst_en  = r_dstEn;
  assign bus.grant   = r_grant;
  assign bus.src_err = r_srcErr;
  assign bus.busy    = r_busy;

  // Single FSM with registered outputs. Every output is set on the edge
  // that enters the state it belongs to, so the pulses line up with the
  // state register. The source and destination are captured in IDLE, so
  // later changes by the requester cannot disturb the transfer. The mask
  // set on leaving LOAD keeps the just-served requester out of the next
  // IDLE arbitration only; IDLE clears it again.
  always_ff @(posedge clock) begin
    if (clear) begin
      r_state   <= ST_IDLE;
      r_select  <= SEL_IDLE_W;
      r_dstEn   <= '0;
      r_holdDst <= '0;
      r_grant   <= '0;
      r_winOh   <= '0;
      r_mask    <= '0;
      r_srcErr  <= 1'b0;
      r_busy    <= 1'b0;
`ifndef BUS_XFER_SCHED_FIXED_PRIO_EN
      r_ptr     <= '0;
      r_winIdx  <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_mask   <= '0;
          r_grant  <= '0;
          r_dstEn  <= '0;
          r_srcErr <= 1'b0;
          if (w_anyElig) begin
            r_select  <= w_src;
            r_holdDst <= w_dst;
            r_winOh   <= w_winner;
`ifndef BUS_XFER_SCHED_FIXED_PRIO_EN
            r_winIdx  <= w_winIdx;
`endif
            r_busy    <= 1'b1;
            r_state   <= ST_DRIVE;
          end else begin
            r_select <= SEL_IDLE_W;
            r_busy   <= 1'b0;
          end
        end
        ST_DRIVE: begin
          r_busy  <= 1'b1;
          r_grant <= r_winOh;
          if (r_select <= SRC_MAX_W) begin
            r_dstEn  <= r_holdDst;
            r_srcErr <= 1'b0;
          end else begin
            r_dstEn  <= '0;
            r_srcErr <= 1'b1;
          end
          r_state <= ST_LOAD;
        end
        ST_LOAD: begin
          r_select <= SEL_IDLE_W;
          r_dstEn  <= '0;
          r_grant  <= '0;
          r_srcErr <= 1'b0;
          r_busy   <= 1'b0;
          r_mask   <= r_winOh;
`ifndef BUS_XFER_SCHED_FIXED_PRIO_EN
          if (r_winIdx == IDX_W'(NUM_REQ - 1)) begin
            r_ptr <= '0;
          end else begin
            r_ptr <= r_winIdx + 1'b1;
          end
`endif
          r_state <= ST_IDLE;
        end
        default: begin
          r_select <= SEL_IDLE_W;
          r_dstEn  <= '0;
          r_grant  <= '0;
          r_srcErr <= 1'b0;
          r_busy   <= 1'b0;
          r_mask   <= '0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_xfer_sched.sv
// ----------------------------------------------------------------------------
// tb_bus_xfer_sched
// Directed bench for bus_xfer_sched. Each expected transfer (grant, load
// enables, error flag, select and the cycle it must appear in) is queued
// when the request is posted; a monitor on the falling edge pops and
// compares whenever the scheduler pulses grant, dst_en or src_err.
// Build option: BUS_XFER_SCHED_FIXED_PRIO_EN adds the fixed-priority case.
// ----------------------------------------------------------------------------
module tb_bus_xfer_sched;

  localparam int NREQ = 4;
  localparam int SW   = 5;
  localparam int DW   = 24;

  typedef struct {
    logic [NREQ-1:0] grant;
    logic [DW-1:0]   dst;
    logic            err;
    logic [SW-1:0]   sel;
    int              cyc;
  } exp_t;

  logic clock = 1'b0;
  logic clear;
  int   cyc = 0;
  int   numChecks = 0;
  int   numFails = 0;
  int   p;
  exp_t expQ[$];

  bus_xfer_sched_if #(.NUM_REQ(NREQ), .SEL_W(SW), .DST_W(DW)) busIf ();

  bus_xfer_sched #(
    .NUM_REQ (NREQ),
    .SEL_W   (SW),
    .DST_W   (DW)
  ) dut (
    .clock (clock),
    .clear (clear),
    .bus   (busIf)
  );

  // Free-running clock and a cycle count of rising edges seen so far.
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // One comparison; every check in the bench goes through here.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    numChecks++;
    if (actual !== expected) begin
      numFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Post (or withdraw) one requester's transfer.
  task automatic applyStimulus(input int idx, input logic [SW-1:0] src, input logic [DW-1:0] dst, input logic on);
    busIf.req_src[idx*SW +: SW] = src;
    busIf.req_dst[idx*DW +: DW] = dst;
    busIf.req[idx] = on;
  endtask

  task automatic expectXfer(input logic [NREQ-1:0] g, input logic [DW-1:0] d, input logic e,
                            input logic [SW-1:0] s, input int c);
    exp_t x;
    x.grant = g;
    x.dst   = d;
    x.err   = e;
    x.sel   = s;
    x.cyc   = c;
    expQ.push_back(x);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic resetDut();
    clear = 1'b1;
    busIf.req = '0;
    tick(2);
    clear = 1'b0;
  endtask

  // Scoreboard monitor: any pulse must match the oldest queued transfer,
  // including the cycle in which it was due.
  always @(negedge clock) begin
    if ((busIf.grant != '0) || (busIf.dst_en != '0) || busIf.src_err) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpectedPulse", 32'({busIf.src_err, busIf.dst_en, busIf.grant}), 32'd0);
      end else begin
        exp_t x;
        x = expQ.pop_front();
        checkOutput("grant", 32'(busIf.grant), 32'(x.grant));
        checkOutput("dstEn", 32'(busIf.dst_en), 32'(x.dst));
        checkOutput("srcErr", 32'(busIf.src_err), 32'(x.err));
        checkOutput("loadSelect", 32'(busIf.select), 32'(x.sel));
        checkOutput("loadCycle", 32'(cyc), 32'(x.cyc));
      end
    end
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected end of stimulus");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus, one scenario after another.
  initial begin
    clear = 1'b1;
    busIf.req = '0;
    busIf.req_src = '0;
    busIf.req_dst = '0;
    tick(2);
    checkOutput("resetSelect", 32'(busIf.select), 32'd31);
    checkOutput("resetDstEn", 32'(busIf.dst_en), 32'd0);
    checkOutput("resetGrant", 32'(busIf.grant), 32'd0);
    checkOutput("resetSrcErr", 32'(busIf.src_err), 32'd0);
    checkOutput("resetBusy", 32'(busIf.busy), 32'd0);
    clear = 1'b0;
    tick(1);

    $display("[TB] single request");
    p = cyc;
    applyStimulus(0, 5'd5, 24'h000008, 1'b1);
    expectXfer(4'b0001, 24'h000008, 1'b0, 5'd5, p + 2);
    tick(1);
    checkOutput("driveSelect", 32'(busIf.select), 32'd5);
    checkOutput("driveBusy", 32'(busIf.busy), 32'd1);
    checkOutput("driveDstEn", 32'(busIf.dst_en), 32'd0);
    tick(1);
    checkOutput("loadBusy", 32'(busIf.busy), 32'd1);
    tick(1);
    busIf.req[0] = 1'b0;
    checkOutput("afterSelect", 32'(busIf.select), 32'd31);
    checkOutput("afterBusy", 32'(busIf.busy), 32'd0);
    tick(2);

    $display("[TB] four requesters round robin");
    resetDut();
    p = cyc;
    for (int i = 0; i < NREQ; i++) begin
      applyStimulus(i, SW'(i + 1), DW'(1) << (i + 4), 1'b1);
      expectXfer(NREQ'(1) << i, DW'(1) << (i + 4), 1'b0, SW'(i + 1), p + 2 + 3 * i);
    end
    for (int i = 0; i < NREQ; i++) begin
      tick(3);
      busIf.req[i] = 1'b0;
    end
    tick(3);

    $display("[TB] held request is not re-served immediately");
    resetDut();
    p = cyc;
    applyStimulus(2, 5'd7, 24'h400002, 1'b1);
    expectXfer(4'b0100, 24'h400002, 1'b0, 5'd7, p + 2);
    expectXfer(4'b0100, 24'h400002, 1'b0, 5'd7, p + 6);
    tick(4);
    checkOutput("maskedIdleBusy", 32'(busIf.busy), 32'd0);
    checkOutput("maskedIdleSelect", 32'(busIf.select), 32'd31);
    tick(3);
    busIf.req[2] = 1'b0;
    tick(3);

    $display("[TB] invalid source");
    p = cyc;
    applyStimulus(0, 5'd26, 24'h000001, 1'b1);
    expectXfer(4'b0001, 24'h000000, 1'b1, 5'd26, p + 2);
    tick(3);
    busIf.req[0] = 1'b0;
    tick(1);

    $display("[TB] source boundary and empty destination");
    p = cyc;
    applyStimulus(1, 5'd23, 24'h000000, 1'b1);
    applyStimulus(3, 5'd24, 24'h000020, 1'b1);
    expectXfer(4'b0010, 24'h000000, 1'b0, 5'd23, p + 2);
    expectXfer(4'b1000, 24'h000000, 1'b1, 5'd24, p + 5);
    tick(3);
    busIf.req[1] = 1'b0;
    tick(3);
    busIf.req[3] = 1'b0;
    tick(2);

    $display("[TB] clear during DRIVE");
    applyStimulus(0, 5'd3, 24'h000004, 1'b1);
    tick(1);
    checkOutput("abortDriveSelect", 32'(busIf.select), 32'd3);
    clear = 1'b1;
    busIf.req = '0;
    tick(1);
    checkOutput("abortSelect", 32'(busIf.select), 32'd31);
    checkOutput("abortBusy", 32'(busIf.busy), 32'd0);
    checkOutput("abortDstEn", 32'(busIf.dst_en), 32'd0);
    checkOutput("abortGrant", 32'(busIf.grant), 32'd0);
    clear = 1'b0;
    tick(6);

`ifdef BUS_XFER_SCHED_FIXED_PRIO_EN
    $display("[TB] fixed priority with two held requests");
    resetDut();
    p = cyc;
    applyStimulus(1, 5'd9, 24'h000400, 1'b1);
    applyStimulus(2, 5'd10, 24'h000800, 1'b1);
    expectXfer(4'b0010, 24'h000400, 1'b0, 5'd9, p + 2);
    expectXfer(4'b0100, 24'h000800, 1'b0, 5'd10, p + 5);
    expectXfer(4'b0010, 24'h000400, 1'b0, 5'd9, p + 8);
    expectXfer(4'b0100, 24'h000800, 1'b0, 5'd10, p + 11);
    tick(12);
    busIf.req = '0;
    tick(3);
`endif

    tick(3);
    checkOutput("scoreboardDrained", 32'(expQ.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
